// File: rtl/cook_sequencer.sv
// Microwave cooking-session sequencer: programmed-time countdown on a 1 Hz tick,
// button/door handling, power-duty gating of the magnetron and end-of-cook beep.
module cook_sequencer #(
    parameter int TIME_W      = 13,
    parameter int MAX_SECS    = 5999,
    parameter int DUTY_PERIOD = 10,
    parameter int BEEP_TICKS  = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tick,
    input  logic              startn,
    input  logic              stopn,
    input  logic              clearn,
    input  logic              door_closed,
    input  logic              load,
    input  logic [TIME_W-1:0] time_in,
    input  logic [3:0]        power,
    output logic              timer_done,
    output logic              mag_enable,
    output logic [TIME_W-1:0] remaining,
    output logic [2:0]        state,
    output logic              beep
);
    localparam int PHASE_W = ($clog2(DUTY_PERIOD) > 4) ? $clog2(DUTY_PERIOD) : 4;
    localparam int BCNT_W  = $clog2(BEEP_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   remaining_q, remaining_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [3:0]          power_q, power_d;
    logic [BCNT_W-1:0]   beep_cnt_q, beep_cnt_d;
    logic                startn_q, stopn_q, clearn_q;
    logic                start_press, stop_press, clear_press, any_press;

    function automatic logic [TIME_W-1:0] sat_time(input logic [TIME_W-1:0] t);
        return (t > TIME_W'(MAX_SECS)) ? TIME_W'(MAX_SECS) : t;
    endfunction

    function automatic logic [3:0] clamp_power(input logic [3:0] p);
        return (p == 4'd0 || p > 4'd10) ? 4'd10 : p;
    endfunction

    // A press is the falling edge of the button level, so a held button fires once.
    assign start_press = startn_q & ~startn;
    assign stop_press  = stopn_q  & ~stopn;
    assign clear_press = clearn_q & ~clearn;
    assign any_press   = start_press | stop_press | clear_press;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            phase_q     <= '0;
            power_q     <= 4'd10;
            beep_cnt_q  <= '0;
            startn_q    <= 1'b1;
            stopn_q     <= 1'b1;
            clearn_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            phase_q     <= phase_d;
            power_q     <= power_d;
            beep_cnt_q  <= beep_cnt_d;
            startn_q    <= startn;
            stopn_q     <= stopn;
            clearn_q    <= clearn;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        phase_d     = phase_q;
        power_d     = power_q;
        beep_cnt_d  = beep_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load && time_in != '0) begin
                    state_d     = S_READY;
                    remaining_d = sat_time(time_in);
                end
            end
            S_READY: begin
                if (clear_press) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end else if (load) begin
                    if (time_in == '0) begin
                        state_d     = S_IDLE;
                        remaining_d = '0;
                    end else begin
                        remaining_d = sat_time(time_in);
                    end
                end else if (start_press && !stop_press && door_closed) begin
                    state_d = S_COOK;
                    phase_d = '0;
                    power_d = clamp_power(power);
                end
            end
            S_COOK: begin
                // Door-open and stop outrank the tick, so a coincident tick is dropped.
                if (clear_press) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end else if (!door_closed || stop_press) begin
                    state_d = S_PAUSE;
                end else if (tick && remaining_q != '0) begin
                    remaining_d = remaining_q - TIME_W'(1);
                    phase_d     = (phase_q == PHASE_W'(DUTY_PERIOD - 1)) ? '0 : phase_q + PHASE_W'(1);
                    if (remaining_q == TIME_W'(1)) begin
                        state_d    = S_DONE;
                        beep_cnt_d = '0;
                    end
                end
            end
            S_PAUSE: begin
                if (clear_press || stop_press) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end else if (start_press && door_closed) begin
                    state_d = S_COOK;
                end
            end
            S_DONE: begin
                if (any_press || !door_closed) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (beep_cnt_q == BCNT_W'(BEEP_TICKS - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        beep_cnt_d = beep_cnt_q + BCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                remaining_d = '0;
            end
        endcase
    end

    // Outputs decode registers only; no input reaches an output combinationally.
    always_comb begin
        state      = state_q;
        remaining  = remaining_q;
        timer_done = (remaining_q == '0);
        mag_enable = (state_q == S_COOK) && (phase_q < PHASE_W'(power_q));
        beep       = (state_q == S_DONE);
    end
endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer: a rule-level session model is checked against
// the DUT every cycle, plus literal spot checks at the key points of each scenario.
module tb_cook_sequencer;
    localparam int TIME_W      = 13;
    localparam int MAX_SECS    = 5999;
    localparam int DUTY_PERIOD = 10;
    localparam int BEEP_TICKS  = 3;

    logic              clk = 1'b0;
    logic              resetn, tick, startn, stopn, clearn, door_closed, load;
    logic [TIME_W-1:0] time_in;
    logic [3:0]        power;
    logic              timer_done, mag_enable, beep;
    logic [TIME_W-1:0] remaining;
    logic [2:0]        state;

    int n_checks = 0;
    int n_fail   = 0;

    cook_sequencer #(
        .TIME_W(TIME_W), .MAX_SECS(MAX_SECS), .DUTY_PERIOD(DUTY_PERIOD), .BEEP_TICKS(BEEP_TICKS)
    ) dut (
        .clk(clk), .resetn(resetn), .tick(tick), .startn(startn), .stopn(stopn),
        .clearn(clearn), .door_closed(door_closed), .load(load), .time_in(time_in),
        .power(power), .timer_done(timer_done), .mag_enable(mag_enable),
        .remaining(remaining), .state(state), .beep(beep)
    );

    always #5 clk = ~clk;

    // Session model: counts elapsed cook ticks and derives the duty window by modulo.
    localparam int IDLE = 0, READY = 1, COOK = 2, PAUSE = 3, DONE = 4;
    int m_st, m_rem, m_elapsed, m_pow, m_done_ticks;
    bit m_pstart, m_pstop, m_pclear, m_valid = 0;

    always @(posedge clk) begin
        bit ps, pt, pc;
        if (!resetn) begin
            m_st = IDLE; m_rem = 0; m_elapsed = 0; m_pow = 10; m_done_ticks = 0;
            m_pstart = 1; m_pstop = 1; m_pclear = 1; m_valid = 1;
        end else begin
            ps = m_pstart && !startn;
            pt = m_pstop  && !stopn;
            pc = m_pclear && !clearn;
            case (m_st)
                IDLE: if (load && time_in != 0) begin
                    m_st = READY; m_rem = (int'(time_in) > MAX_SECS) ? MAX_SECS : int'(time_in);
                end
                READY: begin
                    if (pc) begin m_st = IDLE; m_rem = 0; end
                    else if (load) begin
                        if (time_in == 0) begin m_st = IDLE; m_rem = 0; end
                        else m_rem = (int'(time_in) > MAX_SECS) ? MAX_SECS : int'(time_in);
                    end else if (ps && !pt && door_closed) begin
                        m_st = COOK; m_elapsed = 0;
                        m_pow = (power == 0 || power > 10) ? 10 : int'(power);
                    end
                end
                COOK: begin
                    if (pc) begin m_st = IDLE; m_rem = 0; end
                    else if (!door_closed || pt) m_st = PAUSE;
                    else if (tick && m_rem > 0) begin
                        m_rem--; m_elapsed++;
                        if (m_rem == 0) begin m_st = DONE; m_done_ticks = 0; end
                    end
                end
                PAUSE: begin
                    if (pc || pt) begin m_st = IDLE; m_rem = 0; end
                    else if (ps && door_closed) m_st = COOK;
                end
                DONE: begin
                    if (ps || pt || pc || !door_closed) m_st = IDLE;
                    else if (tick) begin
                        m_done_ticks++;
                        if (m_done_ticks == BEEP_TICKS) m_st = IDLE;
                    end
                end
                default: m_st = IDLE;
            endcase
            m_pstart = startn; m_pstop = stopn; m_pclear = clearn;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("state",      int'(state),      m_st);
            chk("remaining",  int'(remaining),  m_rem);
            chk("timer_done", int'(timer_done), (m_rem == 0) ? 1 : 0);
            chk("beep",       int'(beep),       (m_st == DONE) ? 1 : 0);
            chk("mag_enable", int'(mag_enable),
                (m_st == COOK && (m_elapsed % DUTY_PERIOD) < m_pow) ? 1 : 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_tick();
        tick = 1; step(1); tick = 0; step(1);
    endtask
    task automatic do_load(input int t);
        load = 1; time_in = TIME_W'(t); step(1); load = 0; step(1);
    endtask
    task automatic press_start(); startn = 0; step(1); startn = 1; step(1); endtask
    task automatic press_stop();  stopn  = 0; step(1); stopn  = 1; step(1); endtask
    task automatic press_clear(); clearn = 0; step(1); clearn = 1; step(1); endtask

    initial begin
        resetn = 0; tick = 0; startn = 1; stopn = 1; clearn = 1;
        door_closed = 1; load = 0; time_in = '0; power = 4'd10;
        step(2);
        chk("rst_state", int'(state), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_timer_done", int'(timer_done), 1);
        chk("rst_mag", int'(mag_enable), 0);
        chk("rst_beep", int'(beep), 0);
        resetn = 1; step(1);

        // Zero load in IDLE is ignored
        do_load(0);
        chk("load0_state", int'(state), 0);

        // Scenario 1: 5 s at full power, then beep for three ticks
        do_load(5);
        chk("s1_ready", int'(state), 1);
        press_start();
        chk("s1_cook", int'(state), 2);
        chk("s1_mag", int'(mag_enable), 1);
        for (int i = 0; i < 4; i++) begin do_tick(); step(1); end
        chk("s1_rem1", int'(remaining), 1);
        do_tick();
        chk("s1_done", int'(state), 4);
        chk("s1_timer_done", int'(timer_done), 1);
        do_tick(); do_tick();
        chk("s1_beep2", int'(beep), 1);
        do_tick();
        chk("s1_idle", int'(state), 0);
        chk("s1_beep_off", int'(beep), 0);

        // Scenario 2: power 3 duty window, then power 0 treated as full
        power = 4'd3;
        do_load(20); press_start();
        chk("s2_mag_t0", int'(mag_enable), 1);
        for (int i = 0; i < 3; i++) do_tick();
        chk("s2_mag_t3", int'(mag_enable), 0);
        for (int i = 0; i < 9; i++) do_tick();
        press_clear();
        power = 4'd0;
        do_load(20); press_start();
        for (int i = 0; i < 9; i++) do_tick();
        chk("s2_pow0_t9", int'(mag_enable), 1);
        do_tick();
        press_clear();
        power = 4'd10;

        // Scenario 3: door opens on the same cycle as a tick
        do_load(12); press_start();
        door_closed = 0; tick = 1; step(1); tick = 0; step(1);
        chk("s3_pause", int'(state), 3);
        chk("s3_rem12", int'(remaining), 12);
        door_closed = 1; step(1);
        press_start();
        chk("s3_resume", int'(state), 2);
        do_tick();
        chk("s3_rem11", int'(remaining), 11);
        press_clear();

        // Scenario 4: start with door open is ignored; stop twice ends the session
        do_load(10);
        door_closed = 0; step(1);
        press_start();
        chk("s4_stay_ready", int'(state), 1);
        door_closed = 1; step(1);
        press_start();
        press_stop();
        chk("s4_pause", int'(state), 3);
        press_stop();
        chk("s4_idle", int'(state), 0);
        chk("s4_rem0", int'(remaining), 0);

        // Scenario 5: simultaneous buttons, held start, saturating load
        do_load(10); press_start();
        clearn = 0; stopn = 0; startn = 0; step(1);
        clearn = 1; stopn = 1; startn = 1; step(1);
        chk("s5_clear_wins", int'(state), 0);
        do_load(9);
        startn = 0; step(10);
        press_stop();
        step(38);
        chk("s5_held_start", int'(state), 3);
        startn = 1; step(1);
        press_clear();
        do_load(8000);
        chk("s5_sat", int'(remaining), MAX_SECS);
        chk("s5_sat_state", int'(state), 1);

        // Scenario 6: reset in the middle of cooking
        press_start(); do_tick(); do_tick();
        chk("s6_rem", int'(remaining), MAX_SECS - 2);
        resetn = 0; step(1); resetn = 1;
        chk("s6_state", int'(state), 0);
        chk("s6_rem0", int'(remaining), 0);
        chk("s6_mag", int'(mag_enable), 0);
        chk("s6_timer_done", int'(timer_done), 1);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
